// File: rtl/ula.sv
// ula: 8-bit arithmetic/logic unit with a registered 9-bit result and zero flag.
// s[8] carries the carry, borrow or shifted-out bit of the selected operation.
module ula (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] opcode,
    output logic [8:0] s,
    input  logic       clk,
    input  logic       rst,
    output logic       z
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    op_e        op;
    logic [8:0] s_d, s_q;
    logic       z_d, z_q;

    assign op = op_e'(opcode);

    // SUB wraps in 9 bits, so bit 8 of the difference is exactly the borrow (a < b).
    always_comb begin
        s_d = 9'h000;
        unique case (op)
            OP_ADD: s_d = {1'b0, a} + {1'b0, b};
            OP_SUB: s_d = {1'b0, a} - {1'b0, b};
            OP_AND: s_d = {1'b0, a & b};
            OP_OR:  s_d = {1'b0, a | b};
            OP_XOR: s_d = {1'b0, a ^ b};
            OP_NOT: s_d = {1'b0, ~a};
            OP_SHL: s_d = {a[7], a[6:0], 1'b0};
            OP_SHR: s_d = {a[0], 1'b0, a[7:1]};
            default: s_d = 9'h000;
        endcase
        z_d = (s_d[7:0] == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= 9'h000;
            z_q <= 1'b1;
        end else begin
            s_q <= s_d;
            z_q <= z_d;
        end
    end

    assign s = s_q;
    assign z = z_q;

endmodule

// File: tb/tb_ula.sv
// Directed self-checking bench for ula: reset, every opcode, carry/borrow/shift-out
// boundaries, the zero flag and one-cycle latency with a mid-stream reset.
module tb_ula;

   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] opcode;
   logic [8:0] s;
   logic       clock;
   logic       reset;
   logic       z;

   int checkCount;
   int failCount;

   ula dut (
      .a      (a),
      .b      (b),
      .opcode (opcode),
      .s      (s),
      .clk    (clock),
      .rst    (reset),
      .z      (z)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h", tag, observed, expected);
      end
   endtask

   // Drive one input vector, clock it in, and sample 1 ns after the edge.
   task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn, input logic [2:0] opIn, input logic rstIn);
      a = aIn;
      b = bIn;
      opcode = opIn;
      reset = rstIn;
      @(posedge clock);
      #1;
   endtask

   // Apply a vector and check both the result and the zero flag.
   task automatic runVector(input string tag, input logic [7:0] aIn, input logic [7:0] bIn, input logic [2:0] opIn,
                            input logic rstIn, input logic [8:0] expS, input logic expZ);
      applyStimulus(aIn, bIn, opIn, rstIn);
      checkOutput({tag, ".s"}, s, expS);
      checkOutput({tag, ".z"}, {8'h00, z}, {8'h00, expZ});
   endtask

   // Watchdog so the run always ends even if the clock stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Expected results for the latency sweep with a = 0xA5, b = 0x5A, opcodes 0..7.
   logic [8:0] sweepS [8];
   logic       sweepZ [8];

   initial begin
      checkCount = 0;
      failCount  = 0;
      a = 8'h00;
      b = 8'h00;
      opcode = 3'b000;
      reset = 1'b1;

      sweepS[0] = 9'h0FF; sweepZ[0] = 1'b0;
      sweepS[1] = 9'h04B; sweepZ[1] = 1'b0;
      sweepS[2] = 9'h000; sweepZ[2] = 1'b1;
      sweepS[3] = 9'h0FF; sweepZ[3] = 1'b0;
      sweepS[4] = 9'h0FF; sweepZ[4] = 1'b0;
      sweepS[5] = 9'h05A; sweepZ[5] = 1'b0;
      sweepS[6] = 9'h14A; sweepZ[6] = 1'b0;
      sweepS[7] = 9'h152; sweepZ[7] = 1'b0;

      // Reset held for two edges with all-ones operands, then release.
      runVector("rst1",    8'hFF, 8'hFF, 3'b000, 1'b1, 9'h000, 1'b1);
      runVector("rst2",    8'hFF, 8'hFF, 3'b000, 1'b1, 9'h000, 1'b1);
      runVector("rstRel",  8'hFF, 8'hFF, 3'b000, 1'b0, 9'h1FE, 1'b0);

      // Arithmetic including carry-out and borrow boundaries.
      runVector("add1",    8'h01, 8'h01, 3'b000, 1'b0, 9'h002, 1'b0);
      runVector("addCy",   8'hFF, 8'h01, 3'b000, 1'b0, 9'h100, 1'b1);
      runVector("add80",   8'h80, 8'h80, 3'b000, 1'b0, 9'h100, 1'b1);
      runVector("sub1",    8'h05, 8'h03, 3'b001, 1'b0, 9'h002, 1'b0);
      runVector("subBw",   8'h03, 8'h05, 3'b001, 1'b0, 9'h1FE, 1'b0);
      runVector("subEq",   8'h42, 8'h42, 3'b001, 1'b0, 9'h000, 1'b1);

      // Logic operations.
      runVector("and",     8'hF0, 8'h3C, 3'b010, 1'b0, 9'h030, 1'b0);
      runVector("or",      8'hF0, 8'h3C, 3'b011, 1'b0, 9'h0FC, 1'b0);
      runVector("xor",     8'hF0, 8'h3C, 3'b100, 1'b0, 9'h0CC, 1'b0);
      runVector("not",     8'hF0, 8'h3C, 3'b101, 1'b0, 9'h00F, 1'b0);

      // Shifts with shifted-out bit landing in s[8].
      runVector("shl81",   8'h81, 8'h00, 3'b110, 1'b0, 9'h102, 1'b0);
      runVector("shr81",   8'h81, 8'h00, 3'b111, 1'b0, 9'h140, 1'b0);
      runVector("shl80",   8'h80, 8'h00, 3'b110, 1'b0, 9'h100, 1'b1);

      // Inputs changing between edges must not disturb the registered output.
      a = 8'h12;
      b = 8'h34;
      opcode = 3'b000;
      #3;
      checkOutput("hold.s", s, 9'h100);
      checkOutput("hold.z", {8'h00, z}, 9'h001);

      // Opcode sweep, one per cycle.
      for (int i = 0; i < 8; i++) begin
         runVector($sformatf("sweep%0d", i), 8'hA5, 8'h5A, 3'(i), 1'b0, sweepS[i], sweepZ[i]);
      end

      // Sweep again with reset pulsed on opcode 4's edge only.
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            runVector("sweepRst", 8'hA5, 8'h5A, 3'(i), 1'b1, 9'h000, 1'b1);
         end else begin
            runVector($sformatf("resweep%0d", i), 8'hA5, 8'h5A, 3'(i), 1'b0, sweepS[i], sweepZ[i]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
